fnd_calc_scan: RTL and testbench
================================

# fnd_calc_scan

Parametrised, sequential successor to the 4-bit calculator/FND path. It captures two WIDTH-bit operands on a start pulse and computes add, subtract, AND or OR. The result is converted to BCD with a multi-cycle shift-add-3 engine. A free-running refresh counter drives a 4-digit, time-multiplexed 7-segment display from registered digit data.

## Interface
- WIDTH, 8, operand width; legal range 4..9, so every result fits 4 digits including sign
- REFRESH_DIV, 100000, clock cycles each digit stays enabled; must be ≥2
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_A  in  WIDTH  operand A, unsigned
- i_B  in  WIDTH  operand B, unsigned
- i_Sel  in  2  operation: 00 add, 01 subtract (A−B), 10 AND, 11 OR
- i_start  in  1  request a calculation; accepted only in IDLE
- o_busy  out  1  high while a calculation is in progress
- o_done  out  1  one-cycle pulse when the display registers take the new result
- o_FND_Digit  out  4  active-low one-hot digit enable; bit 0 = ones digit
- o_FND_Font  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1

## Operation
- FSM states: IDLE, CONVERT, DONE.
- **IDLE:**
  - On i_start=1, capture i_A, i_B and i_Sel, and compute the result.
  - Result width is WIDTH+1. Add is A+B. AND/OR are zero-extended.
  - Subtract: if A≥B, the magnitude is A−B and neg=0. Otherwise the magnitude is B−A and neg=1.
  - After the capture: clear the bit counter, set o_busy=1, go to CONVERT.
- **CONVERT:**
  - Each cycle performs one double-dabble step: add 3 to every BCD nibble ≥5, then shift the magnitude MSB in.
  - After WIDTH+1 steps, go to DONE.
- **DONE:**
  - Load the four BCD digits and neg into the display registers.
  - Pulse o_done, clear o_busy, return to IDLE.
- i_start outside IDLE is ignored; there is no queueing.
- **Display scan:**
  - The refresh counter counts 0..REFRESH_DIV−1 continuously, independent of the FSM.
  - On wrap, the digit index increments mod 4 (0→1→2→3→0).
  - o_FND_Digit = ~(1<<index).
  - o_FND_Font is the registered decode of the display register at the selected digit.
- **Fonts:** 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, minus BF, blank FF.
- When neg=1, digit 3 shows minus.
- The previous result stays displayed during CONVERT.
- **Reset** (any time, including mid-CONVERT):
  - FSM goes to IDLE; o_busy=0, o_done=0.
  - Display registers are set to 0 with neg=0.
  - Refresh counter and index are set to 0.
  - o_FND_Digit=4'b1110, o_FND_Font=8'hC0.
  - A calculation interrupted by reset never asserts o_done, and the display does not change to its result.

## Timing
- Call the edge that samples i_start=1 in IDLE edge 0.
- Edge 0: o_busy rises. The captured result is ready.
- Edges 1..WIDTH+1: conversion steps.
- Edge WIDTH+2:
  - Display registers load, o_done rises and o_busy falls.
  - o_done falls on edge WIDTH+3.
  - Latency is WIDTH+2 cycles (10 at WIDTH=8).
- Font follows the display registers and digit index by one registered stage. The new value is visible on the selected digit from edge WIDTH+3.
- Each digit enable lasts exactly REFRESH_DIV cycles.
- The earliest next accept is edge WIDTH+3.

## Configuration
- Macro: FND_LEADING_ZERO_BLANK_EN.
- **Defined:**
  - Digits above the most significant non-zero digit show blank (FF).
  - Digit 0 is never blanked.
  - A minus sign on digit 3 overrides blanking.
- **Undefined:**
  - All four digits are shown with leading zeros.
  - Minus still replaces digit 3 when neg=1.

## Test plan
All scenarios use WIDTH=8, REFRESH_DIV=4.
- **Reset:** assert i_reset → o_FND_Digit=1110, o_FND_Font=C0, o_busy=0, o_done=0. Scan then steps 1110→1101→1011→0111→1110, 4 cycles each.
- **Add:** A=200, B=155, Sel=00, start → o_done exactly 10 cycles after accept. Digits 0..3 = 92, 92, B0, C0. Digit 3 = FF when blanking is enabled.
- **Subtract:** A=3, B=10, Sel=01 → digit 0 = F8, digits 1–2 = C0 (FF with blanking), digit 3 = BF.
- **AND/OR:** A=F0h, B=3Ch. Sel=10 → display 0048. Sel=11 → display 0252.
- **Start while busy:** pulse i_start at accept+3 with different operands → ignored. Exactly one o_done; the displayed value is from the first operands.
- **Mid-conversion reset:** reset at accept+5 → no o_done. Display returns to 0, FSM is in IDLE. The next start completes normally.

Source files
------------

// File: rtl/fnd_calc_scan.sv
// fnd_calc_scan -- sequential calculator with BCD conversion and a 4-digit
// time-multiplexed 7-segment display.
//
// A start pulse in IDLE captures A/B/Sel and computes a WIDTH+1 bit magnitude
// plus a sign flag. A shift-add-3 (double dabble) engine then converts it to
// four BCD digits, one bit per cycle. When it finishes, the digits are loaded
// into the display registers. A free-running refresh counter scans the four
// digits independently of the calculation.
//
// Parameters:
//   WIDTH        operand width (4..9)
//   REFRESH_DIV  cycles each digit stays enabled (>= 2)
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_A, i_B              unsigned operands
//   i_Sel                 00 add, 01 subtract (A-B), 10 AND, 11 OR
//   i_start               calculation request, honoured only in IDLE
//   o_busy                calculation in progress
//   o_done                one-cycle pulse when the display takes the result
//   o_FND_Digit           active-low one-hot digit enable, bit 0 = ones
//   o_FND_Font            active-low segments {dp,g,f,e,d,c,b,a}
// Optional feature:
//   FND_LEADING_ZERO_BLANK_EN  blank leading zero digits (digit 0 never blank)
module fnd_calc_scan #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [1:0]       i_Sel,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_FND_Digit,
  output logic [7:0]       o_FND_Font
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   mag_q, mag_d;
  logic             neg_q, neg_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0][3:0]  disp_q, disp_d;
  logic             dneg_q, dneg_d;

  logic [RW-1:0]    refresh_q;
  logic [1:0]       idx_q;
  logic [7:0]       font_q, font_d;

  // ---------------------------------------------------------------- result
  logic [WIDTH:0] a_x, b_x, res;
  logic           res_neg;

  assign a_x = {1'b0, i_A};
  assign b_x = {1'b0, i_B};

  always_comb begin
    res     = '0;
    res_neg = 1'b0;
    case (i_Sel)
      2'b00: res = a_x + b_x;
      2'b01: begin
        // Sign-magnitude: subtract the smaller from the larger.
        if (i_A >= i_B) res = a_x - b_x;
        else begin
          res     = b_x - a_x;
          res_neg = 1'b1;
        end
      end
      2'b10: res = a_x & b_x;
      default: res = a_x | b_x;
    endcase
  end

  // ------------------------------------------------------- double dabble
  logic [15:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 4; n++)
      if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '0;
      dneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      dneg_q  <= dneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    disp_d  = disp_q;
    dneg_d  = dneg_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mag_d   = res;
          neg_d   = res_neg;
          bcd_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d = {bcd_adj[14:0], mag_q[WIDTH]};
        mag_d = {mag_q[WIDTH-1:0], 1'b0};
        bit_d = bit_q + 1'b1;
        // bit_q counts completed steps; this edge performs step WIDTH+1.
        if (bit_q == CW'(WIDTH)) state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = bcd_q;
        dneg_d  = neg_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

  // --------------------------------------------------------- display scan
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  logic blank;

`ifdef FND_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd1: blank = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0) && (disp_q[1] == 4'd0);
      2'd2: blank = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0);
      2'd3: blank = (disp_q[3] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    if (idx_q == 2'd3 && dneg_q) font_d = 8'hBF;
    else if (blank)              font_d = 8'hFF;
    else                         font_d = seg7(disp_q[idx_q]);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      font_q    <= 8'hC0;
    end else begin
      font_q <= font_d;
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        idx_q     <= idx_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
    end
  end

  assign o_FND_Digit = ~(4'b0001 << idx_q);
  assign o_FND_Font  = font_q;

endmodule

// File: tb/tb_fnd_calc_scan.sv
module tb_fnd_calc_scan;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_A, i_B;
  logic [1:0] i_Sel;
  logic       i_start;
  logic       o_busy, o_done;
  logic [3:0] o_FND_Digit;
  logic [7:0] o_FND_Font;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  fnd_calc_scan #(.WIDTH(8), .REFRESH_DIV(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_A(i_A), .i_B(i_B), .i_Sel(i_Sel),
    .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_FND_Digit(o_FND_Digit), .o_FND_Font(o_FND_Font)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept a calculation; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    @(negedge i_clk);
    i_A = a; i_B = b; i_Sel = s; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // lat = number of cycles after the accepting edge until o_done, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Font of digit d, sampled one cycle into a fresh enable window; X on timeout.
  task automatic read_font(input int d, output logic [7:0] f);
    logic [3:0] tgt;
    bit ok1, ok2;
    tgt = ~(4'b0001 << d);
    ok1 = 0; ok2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_FND_Digit != tgt) begin ok1 = 1; break; end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_FND_Digit == tgt) begin ok2 = 1; break; end
    end
    @(negedge i_clk);
    f = (ok1 && ok2) ? o_FND_Font : 8'hxx;
  endtask

  task automatic test_reset;
    logic [3:0] exp_d;
    i_reset = 1'b1; i_A = '0; i_B = '0; i_Sel = '0; i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    n_chk++; if (o_FND_Digit !== 4'b1110) begin n_fail++; $display("FAIL reset_digit got %b exp 1110", o_FND_Digit); end
    n_chk++; if (o_FND_Font !== 8'hC0) begin n_fail++; $display("FAIL reset_font got %h exp C0", o_FND_Font); end
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    n_chk++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", o_done); end
    i_reset = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) @(negedge i_clk);
      exp_d = ~(4'b0001 << ((j / 4) % 4));
      n_chk++;
      if (o_FND_Digit !== exp_d) begin
        n_fail++; $display("FAIL scan_step%0d got %b exp %b", j, o_FND_Digit, exp_d);
      end
    end
  endtask

  task automatic test_add;
    int lat;
    logic [7:0] f;
    logic [7:0] exp_f [4];
    exp_f = '{8'h92, 8'h92, 8'hB0, LZ};
    start_op(8'd200, 8'd155, 2'b00);
    n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_rise got %b exp 1", o_busy); end
    wait_done(lat);
    n_chk++; if (lat !== 10) begin n_fail++; $display("FAIL add_latency got %0d exp 10", lat); end
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_fall got %b exp 0", o_busy); end
    @(negedge i_clk);
    n_chk++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got %b exp 0", o_done); end
    for (int d = 0; d < 4; d++) begin
      read_font(d, f);
      n_chk++; if (f !== exp_f[d]) begin n_fail++; $display("FAIL add_digit%0d got %h exp %h", d, f, exp_f[d]); end
    end
  endtask

  task automatic test_sub;
    int lat;
    logic [7:0] f;
    logic [7:0] exp_f [4];
    exp_f = '{8'hF8, LZ, LZ, 8'hBF};
    start_op(8'd3, 8'd10, 2'b01);
    wait_done(lat);
    n_chk++; if (lat !== 10) begin n_fail++; $display("FAIL sub_latency got %0d exp 10", lat); end
    for (int d = 0; d < 4; d++) begin
      read_font(d, f);
      n_chk++; if (f !== exp_f[d]) begin n_fail++; $display("FAIL sub_digit%0d got %h exp %h", d, f, exp_f[d]); end
    end
  endtask

  task automatic test_logic;
    int lat;
    logic [7:0] f;
    logic [7:0] exp_and [4];
    logic [7:0] exp_or  [4];
    exp_and = '{8'h80, 8'h99, LZ, LZ};    // 0048
    exp_or  = '{8'hA4, 8'h92, 8'hA4, LZ}; // 0252
    start_op(8'hF0, 8'h3C, 2'b10);
    wait_done(lat);
    n_chk++; if (lat !== 10) begin n_fail++; $display("FAIL and_latency got %0d exp 10", lat); end
    for (int d = 0; d < 4; d++) begin
      read_font(d, f);
      n_chk++; if (f !== exp_and[d]) begin n_fail++; $display("FAIL and_digit%0d got %h exp %h", d, f, exp_and[d]); end
    end
    start_op(8'hF0, 8'h3C, 2'b11);
    wait_done(lat);
    n_chk++; if (lat !== 10) begin n_fail++; $display("FAIL or_latency got %0d exp 10", lat); end
    for (int d = 0; d < 4; d++) begin
      read_font(d, f);
      n_chk++; if (f !== exp_or[d]) begin n_fail++; $display("FAIL or_digit%0d got %h exp %h", d, f, exp_or[d]); end
    end
  endtask

  task automatic test_start_while_busy;
    int lat, ndone;
    logic [7:0] f;
    logic [7:0] exp_f [4];
    exp_f = '{8'h92, 8'h92, 8'hB0, LZ};   // 355 from the first operands
    start_op(8'd200, 8'd155, 2'b00);
    lat = -1; ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge i_clk);
      if (o_done) begin ndone++; if (lat < 0) lat = k; end
      if (k == 2) begin i_A = 8'd1; i_B = 8'd1; i_Sel = 2'b01; i_start = 1'b1; end
      if (k == 3) i_start = 1'b0;
    end
    n_chk++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_done_count got %0d exp 1", ndone); end
    n_chk++; if (lat !== 10) begin n_fail++; $display("FAIL busy_latency got %0d exp 10", lat); end
    for (int d = 0; d < 4; d++) begin
      read_font(d, f);
      n_chk++; if (f !== exp_f[d]) begin n_fail++; $display("FAIL busy_digit%0d got %h exp %h", d, f, exp_f[d]); end
    end
  endtask

  task automatic test_mid_reset;
    int lat, ndone;
    logic [7:0] f;
    start_op(8'hF0, 8'h3C, 2'b11);
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", o_busy); end
    n_chk++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", o_done); end
    n_chk++; if (o_FND_Digit !== 4'b1110) begin n_fail++; $display("FAIL midrst_digit got %b exp 1110", o_FND_Digit); end
    n_chk++; if (o_FND_Font !== 8'hC0) begin n_fail++; $display("FAIL midrst_font got %h exp C0", o_FND_Font); end
    @(negedge i_clk);
    i_reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_done) ndone++;
    end
    n_chk++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d exp 0", ndone); end
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_busy got %b exp 0", o_busy); end
    read_font(0, f);
    n_chk++; if (f !== 8'hC0) begin n_fail++; $display("FAIL midrst_digit0 got %h exp C0", f); end
    read_font(2, f);
    n_chk++; if (f !== LZ) begin n_fail++; $display("FAIL midrst_digit2 got %h exp %h", f, LZ); end
    start_op(8'd3, 8'd10, 2'b01);
    wait_done(lat);
    n_chk++; if (lat !== 10) begin n_fail++; $display("FAIL midrst_next_latency got %0d exp 10", lat); end
    read_font(0, f);
    n_chk++; if (f !== 8'hF8) begin n_fail++; $display("FAIL midrst_next_digit0 got %h exp F8", f); end
    read_font(3, f);
    n_chk++; if (f !== 8'hBF) begin n_fail++; $display("FAIL midrst_next_digit3 got %h exp BF", f); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_start_while_busy;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
